// File: rtl/hex_display_scan.sv
// Multi-digit multiplexed hex display driver with load/ack capture, frame-synchronous double buffering,
// anti-ghosting guard, leading-zero blanking and selectable polarity. Optional blinking: HEX_DISPLAY_BLINK_EN.
module hex_display_scan #(
    parameter int NUM_DIGITS   = 8,
    parameter int SCAN_DIV     = 50000,
    parameter int GUARD        = 64,
`ifdef HEX_DISPLAY_BLINK_EN
    parameter int BLINK_FRAMES = 64,
`endif
    parameter int ACTIVE_LOW   = 1
) (
    input  logic                                                   clk,
    input  logic                                                   rst,
    input  logic                                                   load,
    input  logic [4*NUM_DIGITS-1:0]                                value,
    input  logic                                                   blank_lz,
`ifdef HEX_DISPLAY_BLINK_EN
    input  logic [NUM_DIGITS-1:0]                                  blink_mask,
`endif
    output logic                                                   ack,
    output logic                                                   pending,
    output logic [6:0]                                             seg,
    output logic [NUM_DIGITS-1:0]                                  dig_en,
    output logic [((NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1)-1:0] digit_idx
);

    localparam int IDXW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int CNTW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CNTW-1:0] CNT_LAST       = CNTW'(SCAN_DIV - 1);
    localparam logic [CNTW-1:0] CNT_GUARD_LAST = CNTW'(GUARD - 1);
    localparam logic [IDXW-1:0] IDX_LAST       = IDXW'(NUM_DIGITS - 1);
    localparam logic [6:0] SEG_XOR = (ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
    localparam logic [NUM_DIGITS-1:0] EN_XOR = (ACTIVE_LOW != 0) ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};

    typedef enum logic {ST_GUARD, ST_DRIVE} state_t;

    state_t                  r_state;
    logic [CNTW-1:0]         r_slotCnt;
    logic [IDXW-1:0]         r_digitIdx;
    logic [4*NUM_DIGITS-1:0] r_pendBuf;
    logic [4*NUM_DIGITS-1:0] r_shadow;
    logic                    r_pending;
    logic                    r_ack;
    logic [6:0]              r_seg;
    logic [NUM_DIGITS-1:0]   r_digEn;

    logic                    w_slotWrap;
    logic                    w_frameWrap;
    logic [3:0]              w_curNibble;
    logic [NUM_DIGITS-1:0]   w_curOneHot;
    logic [NUM_DIGITS-1:0]   w_lzMask;
    logic                    w_digitBlank;

    function automatic logic [6:0] decodeHex(input logic [3:0] nib);
        logic [6:0] segs;
        case (nib)
            4'h0: segs = 7'b0111111;
            4'h1: segs = 7'b0000110;
            4'h2: segs = 7'b1011011;
            4'h3: segs = 7'b1001111;
            4'h4: segs = 7'b1100110;
            4'h5: segs = 7'b1101101;
            4'h6: segs = 7'b1111101;
            4'h7: segs = 7'b0000111;
            4'h8: segs = 7'b1111111;
            4'h9: segs = 7'b1101111;
            4'hA: segs = 7'b1110111;
            4'hB: segs = 7'b1111100;
            4'hC: segs = 7'b0111001;
            4'hD: segs = 7'b1011110;
            4'hE: segs = 7'b1111001;
            default: segs = 7'b1110001;
        endcase
        return segs;
    endfunction

    assign w_slotWrap  = (r_slotCnt == CNT_LAST);
    assign w_frameWrap = w_slotWrap && (r_digitIdx == IDX_LAST);

    // The state register always mirrors which part of the slot the counter is in.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_slotCnt  <= '0;
            r_digitIdx <= '0;
            r_state    <= ST_GUARD;
        end else if (w_slotWrap) begin
            r_slotCnt  <= '0;
            r_digitIdx <= (r_digitIdx == IDX_LAST) ? '0 : r_digitIdx + IDXW'(1);
            r_state    <= (GUARD == 0) ? ST_DRIVE : ST_GUARD;
        end else begin
            r_slotCnt <= r_slotCnt + CNTW'(1);
            if (r_slotCnt == CNT_GUARD_LAST) begin
                r_state <= ST_DRIVE;
            end
        end
    end

    // A load in the swap cycle lands in the pending buffer while the old pending value moves to the shadow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pendBuf <= '0;
            r_shadow  <= '0;
            r_pending <= 1'b0;
            r_ack     <= 1'b0;
        end else begin
            r_ack <= load;
            if (w_frameWrap && r_pending) begin
                r_shadow <= r_pendBuf;
            end
            if (load) begin
                r_pendBuf <= value;
                r_pending <= 1'b1;
            end else if (w_frameWrap) begin
                r_pending <= 1'b0;
            end
        end
    end

    always_comb begin
        w_curNibble = 4'h0;
        w_curOneHot = '0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (r_digitIdx == IDXW'(k)) begin
                w_curNibble    = r_shadow[4*k +: 4];
                w_curOneHot[k] = 1'b1;
            end
        end
    end

    // A digit is a leading zero when it and every more significant digit are zero; digit 0 always shows.
    always_comb begin
        logic zeroRun;
        zeroRun  = 1'b1;
        w_lzMask = '0;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            zeroRun = zeroRun & (r_shadow[4*k +: 4] == 4'h0);
            if (k > 0) begin
                w_lzMask[k] = zeroRun;
            end
        end
    end

`ifdef HEX_DISPLAY_BLINK_EN
    localparam int FCW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [FCW-1:0] FRAME_LAST = FCW'(BLINK_FRAMES - 1);

    logic [FCW-1:0] r_frameCnt;
    logic           r_phase;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_frameCnt <= '0;
            r_phase    <= 1'b0;
        end else if (w_frameWrap) begin
            if (r_frameCnt == FRAME_LAST) begin
                r_frameCnt <= '0;
                r_phase    <= ~r_phase;
            end else begin
                r_frameCnt <= r_frameCnt + FCW'(1);
            end
        end
    end

    assign w_digitBlank = (blank_lz && |(w_lzMask & w_curOneHot)) ||
                          (r_phase && |(blink_mask & w_curOneHot));
`else
    assign w_digitBlank = blank_lz && |(w_lzMask & w_curOneHot);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_seg   <= SEG_XOR;
            r_digEn <= EN_XOR;
        end else if (r_state == ST_DRIVE) begin
            r_seg   <= SEG_XOR ^ (w_digitBlank ? 7'h00 : decodeHex(w_curNibble));
            r_digEn <= EN_XOR ^ w_curOneHot;
        end else begin
            r_seg   <= SEG_XOR;
            r_digEn <= EN_XOR;
        end
    end

    assign ack       = r_ack;
    assign pending   = r_pending;
    assign seg       = r_seg;
    assign dig_en    = r_digEn;
    assign digit_idx = r_digitIdx;

endmodule

// File: tb/tb_hex_display_scan.sv
// Scoreboard bench for hex_display_scan: 4 digits, 8-cycle slots, 2-cycle guard, active-low outputs.
module tb_hex_display_scan;

    localparam int N  = 4;
    localparam int SD = 8;
    localparam int GD = 2;
    localparam int BOUND = 3 * N * SD;
    localparam logic [6:0] HEXTAB [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                           7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load = 1'b0;
    logic [15:0] value = 16'h0;
    logic        blank_lz = 1'b0;
`ifdef HEX_DISPLAY_BLINK_EN
    logic [3:0]  blink_mask = 4'h0;
`endif
    logic        ack;
    logic        pending;
    logic [6:0]  seg;
    logic [3:0]  dig_en;
    logic [1:0]  digit_idx;

    int total = 0;
    int bad   = 0;

    typedef struct {
        int         digit;
        logic [6:0] seg;
    } exp_t;

    exp_t sbq[$];

    always #5 clk = ~clk;

    hex_display_scan #(
        .NUM_DIGITS(N),
        .SCAN_DIV(SD),
        .GUARD(GD),
`ifdef HEX_DISPLAY_BLINK_EN
        .BLINK_FRAMES(2),
`endif
        .ACTIVE_LOW(1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .load(load),
        .value(value),
        .blank_lz(blank_lz),
`ifdef HEX_DISPLAY_BLINK_EN
        .blink_mask(blink_mask),
`endif
        .ack(ack),
        .pending(pending),
        .seg(seg),
        .dig_en(dig_en),
        .digit_idx(digit_idx)
    );

    // Expected active-low segments for one frame of value v.
    task automatic push_frame(input logic [15:0] v, input bit lz, input logic [3:0] bmask);
        exp_t e;
        bit allz;
        logic [3:0] nib;
        for (int k = 0; k < N; k++) begin
            allz = 1'b1;
            for (int j = k; j < N; j++) begin
                if (v[4*j +: 4] != 4'h0) allz = 1'b0;
            end
            nib = v[4*k +: 4];
            e.digit = k;
            if ((lz && k > 0 && allz) || bmask[k]) e.seg = 7'h7F;
            else e.seg = ~HEXTAB[nib];
            sbq.push_back(e);
        end
    endtask

    task automatic do_load(input logic [15:0] v);
        value = v;
        load  = 1'b1;
        @(negedge clk);
        load  = 1'b0;
        total++;
        if (ack !== 1'b1) begin
            bad++;
            $display("[TB] FAIL load_ack value=%h: got %b want 1", v, ack);
        end
        total++;
        if (pending !== 1'b1) begin
            bad++;
            $display("[TB] FAIL load_pending value=%h: got %b want 1", v, pending);
        end
    endtask

    task automatic wait_pending_fall();
        int i;
        for (i = 0; i < BOUND; i++) begin
            if (pending === 1'b0) break;
            @(negedge clk);
        end
        total++;
        if (i == BOUND) begin
            bad++;
            $display("[TB] FAIL pending_timeout: got pending=%b want 0 within %0d cycles", pending, BOUND);
        end
    endtask

    task automatic sync_frame_start(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < BOUND; i++) begin
            if (digit_idx == 2'd0 && dig_en == 4'hF) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    // Pops one frame from the scoreboard and checks each digit slot as it is driven.
    task automatic observe_frame();
        bit ok;
        int cnt;
        exp_t e;
        logic [3:0] expEn;
        sync_frame_start(ok);
        total++;
        if (!ok) begin
            bad++;
            $display("[TB] FAIL frame_sync: got no frame start want one within %0d cycles", BOUND);
            return;
        end
        for (int k = 0; k < N; k++) begin
            cnt = 0;
            while (dig_en == 4'hF && cnt < BOUND) begin
                cnt++;
                @(negedge clk);
            end
            total++;
            if (cnt !== GD) begin
                bad++;
                $display("[TB] FAIL guard_len slot%0d: got %0d want %0d", k, cnt, GD);
            end
            total++;
            if (sbq.size() == 0) begin
                bad++;
                $display("[TB] FAIL scoreboard_empty slot%0d: got 0 entries want 1", k);
                return;
            end
            e = sbq.pop_front();
            expEn = ~(4'b0001 << e.digit);
            total++;
            if (dig_en !== expEn) begin
                bad++;
                $display("[TB] FAIL dig_en slot%0d: got %h want %h", k, dig_en, expEn);
            end
            total++;
            if (seg !== e.seg) begin
                bad++;
                $display("[TB] FAIL seg digit%0d: got %h want %h", e.digit, seg, e.seg);
            end
            total++;
            if (digit_idx !== 2'(e.digit)) begin
                bad++;
                $display("[TB] FAIL digit_idx slot%0d: got %0d want %0d", k, digit_idx, e.digit);
            end
            cnt = 0;
            while (dig_en != 4'hF && cnt < BOUND) begin
                cnt++;
                @(negedge clk);
            end
            total++;
            if (cnt !== SD - GD) begin
                bad++;
                $display("[TB] FAIL drive_len slot%0d: got %0d want %0d", k, cnt, SD - GD);
            end
        end
    endtask

    task automatic test_reset();
        int i;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if (seg !== 7'h7F) begin bad++; $display("[TB] FAIL reset_seg: got %h want 7f", seg); end
        total++;
        if (dig_en !== 4'hF) begin bad++; $display("[TB] FAIL reset_dig_en: got %h want f", dig_en); end
        total++;
        if (digit_idx !== 2'd0) begin bad++; $display("[TB] FAIL reset_digit_idx: got %0d want 0", digit_idx); end
        total++;
        if (ack !== 1'b0) begin bad++; $display("[TB] FAIL reset_ack: got %b want 0", ack); end
        total++;
        if (pending !== 1'b0) begin bad++; $display("[TB] FAIL reset_pending: got %b want 0", pending); end
        rst = 1'b0;
        @(negedge clk);
        do_load(16'h12AF);
        for (i = 0; i < BOUND; i++) begin
            if (dig_en != 4'hF) break;
            @(negedge clk);
        end
        total++;
        if (i == BOUND) begin bad++; $display("[TB] FAIL drive_timeout: got dig_en=%h want active", dig_en); end
        #2 rst = 1'b1;
        #1;
        total++;
        if (seg !== 7'h7F) begin bad++; $display("[TB] FAIL midreset_seg: got %h want 7f", seg); end
        total++;
        if (dig_en !== 4'hF) begin bad++; $display("[TB] FAIL midreset_dig_en: got %h want f", dig_en); end
        total++;
        if (pending !== 1'b0) begin bad++; $display("[TB] FAIL midreset_pending: got %b want 0", pending); end
        total++;
        if (ack !== 1'b0) begin bad++; $display("[TB] FAIL midreset_ack: got %b want 0", ack); end
        total++;
        if (digit_idx !== 2'd0) begin bad++; $display("[TB] FAIL midreset_digit_idx: got %0d want 0", digit_idx); end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        push_frame(16'h0000, 1'b0, 4'h0);
        push_frame(16'h0000, 1'b0, 4'h0);
        observe_frame();
        observe_frame();
    endtask

    task automatic test_single_load();
        bit ok;
        sync_frame_start(ok);
        do_load(16'h12AF);
        push_frame(16'h12AF, 1'b0, 4'h0);
        @(negedge clk);
        total++;
        if (ack !== 1'b0) begin bad++; $display("[TB] FAIL ack_width: got %b want 0", ack); end
        total++;
        if (pending !== 1'b1) begin bad++; $display("[TB] FAIL pending_hold: got %b want 1", pending); end
        wait_pending_fall();
        observe_frame();
    endtask

    task automatic test_overwrite();
        bit ok;
        sync_frame_start(ok);
        do_load(16'h1111);
        repeat (2) @(negedge clk);
        do_load(16'h2222);
        push_frame(16'h2222, 1'b0, 4'h0);
        wait_pending_fall();
        observe_frame();
    endtask

    task automatic test_leading_zero();
        bit ok;
        blank_lz = 1'b1;
        sync_frame_start(ok);
        do_load(16'h0030);
        push_frame(16'h0030, 1'b1, 4'h0);
        wait_pending_fall();
        observe_frame();
        do_load(16'h0000);
        push_frame(16'h0000, 1'b1, 4'h0);
        wait_pending_fall();
        observe_frame();
        blank_lz = 1'b0;
        push_frame(16'h0000, 1'b0, 4'h0);
        observe_frame();
    endtask

    task automatic test_swap_collision();
        bit ok;
        int i;
        sync_frame_start(ok);
        do_load(16'hABCD);
        for (i = 0; i < BOUND; i++) begin
            if (dig_en == 4'h7) break;
            @(negedge clk);
        end
        total++;
        if (i == BOUND) begin bad++; $display("[TB] FAIL last_digit_timeout: got dig_en=%h want 7", dig_en); end
        repeat (4) @(negedge clk);
        value = 16'h3456;
        load  = 1'b1;
        @(negedge clk);
        load  = 1'b0;
        total++;
        if (ack !== 1'b1) begin bad++; $display("[TB] FAIL swap_ack: got %b want 1", ack); end
        total++;
        if (pending !== 1'b1) begin bad++; $display("[TB] FAIL swap_pending: got %b want 1", pending); end
        push_frame(16'hABCD, 1'b0, 4'h0);
        push_frame(16'h3456, 1'b0, 4'h0);
        observe_frame();
        total++;
        if (pending !== 1'b0) begin bad++; $display("[TB] FAIL swap_pending_clear: got %b want 0", pending); end
        observe_frame();
    endtask

`ifdef HEX_DISPLAY_BLINK_EN
    task automatic test_blink();
        blank_lz   = 1'b0;
        blink_mask = 4'b0001;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        for (int f = 0; f < 6; f++) begin
            push_frame(16'h0000, 1'b0, (f == 2 || f == 3) ? 4'b0001 : 4'b0000);
            observe_frame();
        end
        blink_mask = 4'h0;
    endtask
`endif

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: got no finish want finish before 1ms");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        $display("[TB] starting hex_display_scan bench");
        test_reset();
        test_single_load();
        test_overwrite();
        test_leading_zero();
        test_swap_collision();
`ifdef HEX_DISPLAY_BLINK_EN
        test_blink();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hex_display_scan.md
Name: hex_display_scan

Overview:
- Parametrised multi-digit hex display driver. Successor to the single-digit hex-to-seven-segment decoder.
- Latches an N-digit hex value through a load/ack handshake and double-buffers it so a new value is only shown at a frame boundary.
- Time-multiplexes digits onto one shared segment bus, with an anti-ghosting guard interval, leading-zero blanking and selectable output polarity.
- Sits between datapath blocks (LFSR, counters) and board display pins.

Parameters:
- NUM_DIGITS, 8: number of hex digits, 1..16.
- SCAN_DIV, 50000: clock cycles per digit slot, >= GUARD+2.
- GUARD, 64: cycles at the start of each slot with all digit enables inactive.
- ACTIVE_LOW, 1: 1 = segments and digit enables are active-low; 0 = active-high.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- load  in  1  request to capture value
- value  in  4*NUM_DIGITS  hex value; digit 0 = bits [3:0]
- blank_lz  in  1  1 = suppress leading zeros
- ack  out  1  one-cycle pulse: value captured
- pending  out  1  a captured value is waiting for the frame boundary
- seg  out  7  segments {g,f,e,d,c,b,a}
- dig_en  out  NUM_DIGITS  one-hot digit enable
- digit_idx  out  clog2(NUM_DIGITS) (min 1)  digit currently driven

Behaviour:
- Reset (async, active-high) values:
  - seg = blank; dig_en = all inactive; digit_idx = 0.
  - ack = 0; pending = 0; pending and shadow buffers = 0; slot counter = 0; state = GUARD.
- Handshake:
  - load sampled every cycle. When load=1, value is copied into the pending buffer; next cycle ack=1 for exactly one cycle and pending=1.
  - Load held high captures every cycle and acks every cycle.
  - A load while pending=1 overwrites the pending buffer; the last value wins.
- Frame swap:
  - When the slot counter wraps and digit_idx wraps NUM_DIGITS-1 -> 0, shadow <= pending buffer if pending=1.
  - pending clears in that same cycle.
  - If a load coincides with the swap cycle, the new load wins: the old pending value is swapped in, the new value becomes pending, and pending stays 1.
- Slot counter:
  - Counts 0..SCAN_DIV-1 and wraps.
  - On wrap, digit_idx increments modulo NUM_DIGITS.
- State machine:
  - GUARD (counter < GUARD): dig_en all inactive, seg = blank.
  - Transition GUARD -> DRIVE when the counter reaches GUARD.
  - DRIVE: dig_en has only bit digit_idx active; seg = decode(shadow digit digit_idx) or blank.
  - Transition DRIVE -> GUARD on counter wrap.
- Outputs are registered: seg and dig_en change one cycle after the counter condition.
- Decode, active-high form, {g..a}:
  - 0=0111111, 1=0000110, 2=1011011, 3=1001111
  - 4=1100110, 5=1101101, 6=1111101, 7=0000111
  - 8=1111111, 9=1101111, A=1110111, b=1111100
  - C=0111001, d=1011110, E=1111001, F=1110001
  - Blank = 0000000.
  - ACTIVE_LOW=1 inverts seg and dig_en; blank = 1111111.
- Leading-zero blanking:
  - Applies when blank_lz=1 (sampled live).
  - Digit k is blanked if shadow digits NUM_DIGITS-1..k are all zero and k>0.
  - Digit 0 is never blanked, so value 0 shows a single "0".
- NUM_DIGITS=1: digit_idx is held at 0, and a frame is one slot.

Optional Feature:
- Macro HEX_DISPLAY_BLINK_EN.
- With it defined:
  - Adds input blink_mask (NUM_DIGITS) and parameter BLINK_FRAMES (default 64).
  - A phase bit toggles every BLINK_FRAMES frames and resets to 0 (on phase).
  - While the phase bit is 1, digits whose mask bit is set output seg = blank during DRIVE; dig_en behaviour is unchanged.
- Without it: the port and parameter are absent and no blinking occurs.

Test Plan:
- Reset mid-DRIVE with NUM_DIGITS=4, SCAN_DIV=8, GUARD=2, ACTIVE_LOW=1 -> same cycle: seg=7F, dig_en=4'hF, pending=0, ack=0.
- load=1 for one cycle, value=16'h12AF -> ack pulse one cycle later and pending=1 until frame wrap. Next frame, digit 0..3 seg = 0E, 08, 24, 79; dig_en = E, D, B, 7 during DRIVE and F during the 2 GUARD cycles.
- Two loads (16'h1111, then 16'h2222) within one frame -> only 2222 displayed; 1111 never appears on seg.
- blank_lz=1, value=16'h0030 -> digits 3, 2 = 7F; digit 1 = 30; digit 0 = 40. value=0 -> only digit 0 = 40.
- Load asserted on the exact swap cycle -> old pending shown, new value pending=1, shown the following frame.
- HEX_DISPLAY_BLINK_EN with BLINK_FRAMES=2, blink_mask=4'b0001 -> digit 0 is blank in frames 2-3, visible in frames 0-1 and 4-5; other digits are always visible.
